abft_acc_ctrl: RTL and testbench
================================

Name: abft_acc_ctrl

Overview:
- Sequencer for one `acc_n` checksum accumulator in the ABFT datapath.
- Accepts a vector length, streams that many signed elements into the accumulator over a valid/ready interface, and drives the accumulator's clear on the first element.
- Captures the final sum into a result register with an overflow flag and presents it over a valid/ready result interface.
- Sits between the matrix-row streamer and the checksum comparator.

Parameters:
- aBits, 18, element width (two's complement).
- zBits, 20, accumulator/result width; must be greater than aBits.
- lenBits, 8, width of the vector-length field. Maximum length is 2^lenBits-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a vector; sampled only in IDLE
- len  input  lenBits  element count, latched on accepted start
- in_valid  input  1  element valid
- in_ready  output  1  element accepted when in_valid && in_ready
- in_data  input  aBits  signed element
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_sum  output  zBits  signed vector sum
- out_ovf  output  1  sticky overflow for this vector
- busy  output  1  state != IDLE

Behaviour:
- One clock, synchronous active-high reset, as already decided.
- Reset values: state IDLE; in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0; element counter=0. The embedded `acc_n` is reset by the same rst.
- Reset mid-operation abandons the vector. No result is emitted.
- States:
  - IDLE: start=1 and len!=0 latches len, zeroes the counter, sets first=1, goes to RUN. start=1 and len==0 loads out_sum=0 and out_ovf=0 and goes to RESULT. start outside IDLE is ignored.
  - RUN: in_ready=1.
    - On each transfer, feed in_data to acc_n.a and increment the counter.
    - The first transfer drives acc_n.clear=1; subsequent transfers drive clear=0.
    - Cycles without a transfer drive acc_n.a=0 and clear=0, so the accumulator holds.
    - The transfer where counter==len-1 goes to FLUSH.
  - FLUSH: one cycle, in_ready=0. The last sum is registered in acc_n here. Next edge: out_sum<=acc_n.z, out_ovf<=ovf_sticky, go to RESULT.
  - RESULT: out_valid=1, out_sum and out_ovf held stable. out_valid && out_ready goes to IDLE and clears out_valid. No element is accepted while in RESULT.
- Latency: out_valid asserts 2 cycles after the last element transfer.
- Overflow detection:
  - Register the sign of the sign-extended element (zBits wide) and the sign of the accumulator input (0 when clear) on each transfer.
  - On the next cycle, set ovf_sticky if the two registered signs are equal and acc_n.z's MSB differs from them.
  - ovf_sticky clears on the first-element transfer. Wrap-around in acc_n is modulo 2^zBits; out_sum reports the wrapped value.
- A back-to-back start in the same cycle that RESULT is consumed is not accepted. It is accepted on the following IDLE cycle.

Decomposition:
- Package abft_acc_pkg holds:
  - state enum typedef (IDLE, RUN, FLUSH, RESULT);
  - localparam defaults for aBits, zBits, lenBits.
- One sub-module instance: the existing `acc_n` (aBits, zBits). All control logic stays in abft_acc_ctrl.

Test Plan:
- Directed scenarios, with aBits=18, zBits=20:
  - Reset, then start len=4, elements 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid 2 cycles after the 4th element, out_sum=10, out_ovf=0, back to IDLE.
  - len=3, elements -5,7,-20 with in_valid gaps of 2 cycles, and out_ready held low for 5 cycles -> out_sum=-18 (0xFFFEE) held stable with out_valid=1 until out_ready; in_ready=0 throughout RESULT.
  - Two vectors back to back: [100,100] then [1]. The second vector's sum is 1 -> clear on the first element discards 200.
  - start with len=0 -> out_valid the next cycle, out_sum=0, out_ovf=0; no element is accepted.
  - Eight elements of 131071 (0x1FFFF), giving 1048568 > 524287 -> out_ovf=1 and out_sum equals the wrapped value mod 2^20.
  - Assert rst during RUN after 2 of 4 elements -> all outputs return to reset values next cycle. A subsequent len=1 vector [9] gives out_sum=9.

Source files
------------

// File: rtl/abft_acc_ctrl_pkg.sv
// Shared types and default widths for the ABFT checksum accumulator sequencer.
package abft_acc_pkg;

    localparam int A_BITS_DEF   = 18;
    localparam int Z_BITS_DEF   = 20;
    localparam int LEN_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/abft_acc_ctrl_acc_n.sv
// Signed running accumulator: z <= (clear ? 0 : z) + sext(a), wrapping mod 2^zBits.
module acc_n #(
    parameter int aBits = 18,
    parameter int zBits = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [aBits-1:0] a,
    output logic [zBits-1:0] z
);

    logic [zBits-1:0] z_q;
    logic [zBits-1:0] z_d;
    logic [zBits-1:0] a_ext;

    always_comb begin
        a_ext = {{(zBits-aBits){a[aBits-1]}}, a};
        z_d   = (clear ? '0 : z_q) + a_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) z_q <= '0;
        else     z_q <= z_d;
    end

    assign z = z_q;

endmodule

// File: rtl/abft_acc_ctrl.sv
// Sequences one vector of signed elements through acc_n and hands the final
// sum plus a sticky overflow flag to the checksum comparator.
module abft_acc_ctrl
    import abft_acc_pkg::*;
#(
    parameter int aBits   = A_BITS_DEF,
    parameter int zBits   = Z_BITS_DEF,
    parameter int lenBits = LEN_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [lenBits-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [aBits-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [zBits-1:0]   out_sum,
    output logic               out_ovf,
    output logic               busy
);

    state_t             state_q,     state_d;
    logic [lenBits-1:0] len_q,       len_d;
    logic [lenBits-1:0] cnt_q,       cnt_d;
    logic               first_q,     first_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [zBits-1:0]   out_sum_q,   out_sum_d;
    logic               out_ovf_q,   out_ovf_d;
    logic               busy_q,      busy_d;
    logic               sgn_el_q,    sgn_el_d;
    logic               sgn_acc_q,   sgn_acc_d;
    logic               chk_q,       chk_d;
    logic               ovf_sticky_q, ovf_sticky_d;

    logic               xfer;
    logic               acc_clear;
    logic [aBits-1:0]   acc_a;
    logic [zBits-1:0]   acc_z;
    logic               ovf_now;

    acc_n #(
        .aBits (aBits),
        .zBits (zBits)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .a     (acc_a),
        .z     (acc_z)
    );

    always_comb begin
        xfer      = (state_q == RUN) && in_valid && in_ready_q;
        acc_clear = xfer && first_q;
        acc_a     = xfer ? in_data : '0;

        // Signs of the two adder operands from the previous transfer; the
        // result's sign is checked one cycle later against acc_z.
        sgn_el_d  = xfer ? in_data[aBits-1] : sgn_el_q;
        sgn_acc_d = xfer ? (acc_clear ? 1'b0 : acc_z[zBits-1]) : sgn_acc_q;
        chk_d     = xfer;
        ovf_now   = chk_q && (sgn_el_q == sgn_acc_q) && (acc_z[zBits-1] != sgn_el_q);

        if (acc_clear) ovf_sticky_d = 1'b0;
        else           ovf_sticky_d = ovf_sticky_q | ovf_now;

        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len != '0) begin
                        len_d      = len;
                        cnt_d      = '0;
                        first_d    = 1'b1;
                        in_ready_d = 1'b1;
                        state_d    = RUN;
                    end else begin
                        out_sum_d   = '0;
                        out_ovf_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = RESULT;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d   = cnt_q + lenBits'(1);
                    first_d = 1'b0;
                    if (cnt_q == len_q - lenBits'(1)) begin
                        in_ready_d = 1'b0;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The last element's overflow check resolves in this very
                // cycle, so capture the sticky flag's next value.
                out_sum_d   = acc_z;
                out_ovf_d   = ovf_sticky_d;
                out_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_ovf_q    <= 1'b0;
            busy_q       <= 1'b0;
            sgn_el_q     <= 1'b0;
            sgn_acc_q    <= 1'b0;
            chk_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_ovf_q    <= out_ovf_d;
            busy_q       <= busy_d;
            sgn_el_q     <= sgn_el_d;
            sgn_acc_q    <= sgn_acc_d;
            chk_q        <= chk_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_abft_acc_ctrl.sv
// Directed and random vectors against a plain-arithmetic model of a wrapping
// 20-bit signed sum with per-add overflow detection.
module tb_abft_acc_ctrl;

    localparam int A = 18;
    localparam int Z = 20;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L-1:0] len;
    logic         in_valid;
    logic         in_ready;
    logic [A-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [Z-1:0] out_sum;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int fails  = 0;

    int vec[$];
    int exp_sum;
    int exp_ovf;

    abft_acc_ctrl #(.aBits(A), .zBits(Z), .lenBits(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer add, wrap to signed 20 bits, flag any add that
    // left the representable range.
    task automatic model();
        int w;
        int e;
        w = 0;
        exp_ovf = 0;
        foreach (vec[i]) begin
            e = vec[i];
            w = w + e;
            if (w > 524287 || w < -524288) exp_ovf = 1;
            w = w & 32'hFFFFF;
            if (w >= 524288) w = w - 1048576;
        end
        exp_sum = w & 32'hFFFFF;
    endtask

    // Drive one vector, check handshake timing, result and hold behaviour.
    // next_len >= 0 asserts start in the same cycle the result is consumed.
    task automatic run_vec(input int gap, input int hold, input int next_len);
        int n;
        int i;
        int g;
        int budget;
        logic [Z-1:0] s0;
        n = vec.size();
        model();
        start = 1'b1;
        len   = L'(n);
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (n == 0) begin
            chk("len0_valid", 32'(out_valid), 32'd1);
            chk("len0_in_ready", 32'(in_ready), 32'd0);
        end else begin
            chk("run_in_ready", 32'(in_ready), 32'd1);
            i = 0;
            g = 0;
            budget = 0;
            while (i < n && budget < 2000) begin
                if (i > 0 && g < gap) begin
                    in_valid = 1'b0;
                    in_data  = A'($urandom);
                    g++;
                    step();
                end else begin
                    in_valid = 1'b1;
                    in_data  = A'(vec[i]);
                    if (in_ready) begin
                        i++;
                        g = 0;
                    end
                    step();
                end
                budget++;
            end
            in_valid = 1'b0;
            if (budget >= 2000) chk("element_budget", 32'(i), 32'(n));
            chk("flush_no_valid", 32'(out_valid), 32'd0);
            chk("flush_no_ready", 32'(in_ready), 32'd0);
            step();
            chk("latency2_valid", 32'(out_valid), 32'd1);
        end
        chk("out_sum", 32'(out_sum), 32'(exp_sum));
        chk("out_ovf", 32'(out_ovf), 32'(exp_ovf));
        s0 = out_sum;
        in_valid = 1'b1;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(s0));
            chk("result_no_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (next_len >= 0) begin
            start = 1'b1;
            len   = L'(next_len);
        end
        step();
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // start ignored while busy is not exercised here; basic vector first
        vec = '{1, 2, 3, 4};
        run_vec(0, 0, -1);
        chk("sum10", 32'(out_sum), 32'd10);

        vec = '{-5, 7, -20};
        run_vec(2, 5, -1);
        chk("sum_neg18", 32'(out_sum), 32'hFFFEE);

        vec = '{100, 100};
        run_vec(0, 1, 1);
        vec = '{1};
        run_vec(0, 0, -1);
        chk("clear_discards", 32'(out_sum), 32'd1);

        vec = {};
        run_vec(0, 2, -1);

        vec = {};
        for (int k = 0; k < 8; k++) vec.push_back(131071);
        run_vec(0, 0, -1);
        chk("wrap_sum", 32'(out_sum), 32'hFFFF8);
        chk("wrap_ovf", 32'(out_ovf), 32'd1);

        // Reset mid-RUN after two of four elements
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 18'd50; step();
        in_data = 18'd60; step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        vec = '{9};
        run_vec(0, 0, -1);
        chk("after_rst_sum", 32'(out_sum), 32'd9);

        // Random vectors, including sign-mixed large magnitudes
        for (int r = 0; r < 10; r++) begin
            vec = {};
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                if (r % 2 == 0) vec.push_back(int'($urandom_range(0, 262143)) - 131072);
                else            vec.push_back(int'($urandom_range(100000, 131071)) * ((k % 3 == 2) ? -1 : 1));
            end
            run_vec(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
